rr_stream_mux: RTL and testbench

- N-channel, WIDTH-bit streaming multiplexer with valid/ready handshakes on every input and on the output.
- Selection is made internally by the arbiter, not by an external select; MODE chooses round-robin or fixed-priority arbitration.
- A single registered output stage gives 1-cycle latency and 1 word/cycle throughput.
- Sits where the combinational 2:1 mux is outgrown: merging several producer streams onto one consumer.

---
 rtl/rr_stream_mux_if.sv | 25 ++
 rtl/rr_stream_mux.sv | 89 ++++++++
 tb/tb_rr_stream_mux.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/rr_stream_mux_if.sv
// Handshake bundle for rr_stream_mux: N_CH producer streams in, one merged stream out.
// master = producers/consumer side, slave = the mux itself.
interface rr_stream_mux_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
);
  logic [N_CH-1:0]       in_valid;
  logic [N_CH*WIDTH-1:0] in_data;
  logic [N_CH-1:0]       in_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_sel;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream merger with an internal round-robin or fixed-priority arbiter
// and a single registered output stage (1-cycle latency, 1 word/cycle).
module rr_stream_mux #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2,
  parameter int MODE  = 0
) (
  input logic            clk,
  input logic            rst,
  rr_stream_mux_if.slave bus
);

  logic [N_CH-1:0]  grant_s;
  logic             found_s;
  int               idx_s;
  logic [SEL_W-1:0] sel_s;
  logic [WIDTH-1:0] data_s;
  logic             load_en_s;
  logic [N_CH-1:0]  in_ready_s;
  logic             xfer_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic [SEL_W-1:0] out_sel_r;
  logic [SEL_W-1:0] ptr_r;

  // Arbiter: one-hot grant to the first valid channel in scan order.
  // Round-robin scans upward from ptr+1 with wrap; fixed priority scans from index 0.
  always_comb begin
    grant_s = {N_CH{1'b0}};
    found_s = 1'b0;
    idx_s   = 0;
    if (MODE == 1) begin
      for (int i = 0; i < N_CH; i++) begin
        grant_s[i] = bus.in_valid[i] & ~found_s;
        found_s    = found_s | bus.in_valid[i];
      end
    end else begin
      for (int k = 1; k <= N_CH; k++) begin
        idx_s          = (int'(ptr_r) + k) % N_CH;
        grant_s[idx_s] = bus.in_valid[idx_s] & ~found_s;
        found_s        = found_s | bus.in_valid[idx_s];
      end
    end
  end

  // Grant encoder and data select; the grant is one-hot so OR-reduction is a clean mux.
  always_comb begin
    sel_s  = {SEL_W{1'b0}};
    data_s = {WIDTH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      sel_s  = sel_s  | (SEL_W'(i) & {SEL_W{grant_s[i]}});
      data_s = data_s | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
    end
  end

  // Handshake: accept only when the output register is free or draining, never during reset.
  always_comb begin
    load_en_s  = ~out_valid_r | bus.out_ready;
    in_ready_s = grant_s & {N_CH{load_en_s & ~rst}};
    xfer_s     = |in_ready_s;
  end

  // Output register and round-robin pointer; the pointer moves only on an accepted transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_sel_r   <= {SEL_W{1'b0}};
      ptr_r       <= SEL_W'(N_CH - 1);
    end else if (xfer_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= data_s;
      out_sel_r   <= sel_s;
      ptr_r       <= sel_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_sel   = out_sel_r;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench: one round-robin and one fixed-priority instance; stimulus pushes
// expected {sel,data} words, a negedge monitor pops them on every accepted output word.
module tb_rr_stream_mux;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [9:0] qa[$];
  logic [9:0] qb[$];

  rr_stream_mux_if #(.WIDTH(8), .N_CH(4), .SEL_W(2)) a_if ();
  rr_stream_mux_if #(.WIDTH(8), .N_CH(4), .SEL_W(2)) b_if ();

  rr_stream_mux #(.WIDTH(8), .N_CH(4), .SEL_W(2), .MODE(0)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (a_if)
  );

  rr_stream_mux #(.WIDTH(8), .N_CH(4), .SEL_W(2), .MODE(1)) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int ch);
    qa.push_back({2'(ch), 8'hA0 + 8'(ch)});
  endtask

  task automatic push_b(input int ch);
    qb.push_back({2'(ch), 8'hB0 + 8'(ch)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Monitor: every word the consumer accepts must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (a_if.out_valid === 1'b1 && a_if.out_ready === 1'b1) begin
      if (qa.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rr_unexpected: got sel=%0d data=%0h expected no word", a_if.out_sel, a_if.out_data);
      end else begin
        chk("rr_word", 32'({a_if.out_sel, a_if.out_data}), 32'(qa.pop_front()));
      end
    end
    if (b_if.out_valid === 1'b1 && b_if.out_ready === 1'b1) begin
      if (qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fp_unexpected: got sel=%0d data=%0h expected no word", b_if.out_sel, b_if.out_data);
      end else begin
        chk("fp_word", 32'({b_if.out_sel, b_if.out_data}), 32'(qb.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    a_if.in_valid  = 4'hF;
    a_if.in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    a_if.out_ready = 1'b1;
    b_if.in_valid  = 4'hF;
    b_if.in_data   = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    b_if.out_ready = 1'b1;

    // Reset held two cycles with every channel valid
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
      chk("rst_out_data",  32'(a_if.out_data),  32'd0);
      chk("rst_out_sel",   32'(a_if.out_sel),   32'd0);
      chk("rst_in_ready",  32'(a_if.in_ready),  32'd0);
      chk("rst_in_ready_fp", 32'(b_if.in_ready), 32'd0);
    end

    // Round-robin rotation: 0,1,2,3,0,1 back to back
    push_a(0); push_a(1); push_a(2); push_a(3); push_a(0); push_a(1);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready",    32'(a_if.in_ready), 32'h1);
    chk("post_rst_in_ready_fp", 32'(b_if.in_ready), 32'h1);
    b_if.in_valid = 4'h0;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("rr_no_bubble", 32'(a_if.out_valid), 32'd1);
    end
    a_if.in_valid = 4'h0;

    // Drain: valid falls, data and sel hold
    step();
    chk("drain_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("drain_out_data",  32'(a_if.out_data),  32'hA1);
    chk("drain_out_sel",   32'(a_if.out_sel),   32'd1);

    // Reset while a word is held under backpressure discards it
    a_if.in_valid  = 4'b0001;
    a_if.out_ready = 1'b0;
    step();
    chk("held_out_valid", 32'(a_if.out_valid), 32'd1);
    a_if.in_valid = 4'h0;
    rst = 1'b1;
    step();
    chk("midrst_out_valid", 32'(a_if.out_valid), 32'd0);
    chk("midrst_out_data",  32'(a_if.out_data),  32'd0);
    step();
    rst = 1'b0;
    a_if.out_ready = 1'b1;

    // Skip and wrap: only ch1/ch3 valid, then ch3 alone
    push_a(1); push_a(3); push_a(1); push_a(3);
    a_if.in_valid = 4'b1010;
    repeat (4) step();
    push_a(3); push_a(3); push_a(3);
    a_if.in_valid = 4'b1000;
    repeat (3) step();
    a_if.in_valid = 4'h0;
    step();
    step();

    // Backpressure on word A2, then release goes to ch3
    do_reset();
    push_a(0); push_a(1); push_a(2); push_a(3);
    a_if.in_valid  = 4'hF;
    a_if.out_ready = 1'b1;
    repeat (3) step();
    a_if.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_out_data",  32'(a_if.out_data),  32'hA2);
      chk("stall_out_sel",   32'(a_if.out_sel),   32'd2);
      chk("stall_out_valid", 32'(a_if.out_valid), 32'd1);
      chk("stall_in_ready",  32'(a_if.in_ready),  32'd0);
      step();
    end
    a_if.out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(a_if.in_ready), 32'b1000);
    step();
    a_if.in_valid = 4'h0;
    step();
    step();

    // Fixed priority: ch0 always, then ch1 one cycle after ch0 drops
    do_reset();
    push_b(0); push_b(0); push_b(0);
    b_if.in_valid  = 4'hF;
    b_if.out_ready = 1'b1;
    repeat (3) step();
    b_if.in_valid = 4'b1110;
    push_b(1); push_b(1);
    step();
    chk("fp_after_drop_sel", 32'(b_if.out_sel), 32'd1);
    step();
    b_if.in_valid = 4'h0;
    step();
    step();

    chk("rr_queue_empty", 32'(qa.size()), 32'd0);
    chk("fp_queue_empty", 32'(qb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
